home_alarm_ctrl: RTL

Parametrised, clocked successor of the combinational home alarm. Monitors `N_ZONES` zone switches under a master arm switch and adds an exit delay after arming, an entry delay for designated entry zones, a timed siren with automatic re-arm, and a latched zone-memory output. Sits between the synchronised board switches and the alarm/LED drivers.

---
 rtl/home_alarm_pkg.sv | 23 ++
 rtl/alarm_delay_timer.sv | 30 +++
 rtl/home_alarm_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/home_alarm_pkg.sv
// Shared types and helpers for the home alarm controller.
// Holds the FSM state encoding and the delay-counter width calculation.
package home_alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED,
    EXIT,
    ARMED,
    ENTRY,
    ALARM
  } alarm_state_t;

  // The counter only ever holds load values up to max-1, so clog2(max) bits suffice.
  function automatic int cnt_width(input int a, input int b, input int c);
    int mx;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (mx <= 2) return 1;
    return $clog2(mx);
  endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// Down-counter shared by the exit, entry and siren phases.
// It saturates at zero and never wraps; a load takes priority over a clear.
module alarm_delay_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          clr,
  output logic          zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/home_alarm_ctrl.sv
// Home alarm controller: exit/entry delays, timed siren with automatic re-arm,
// and a zone memory that survives disarm so the tripped zones stay readable.
//
// state    | meaning
// DISARMED | master switch off, zones ignored
// EXIT     | exit delay running after arming, zones ignored
// ARMED    | watching zones
// ENTRY    | entry zone tripped, delay running before siren
// ALARM    | siren on for SIREN_TIME cycles, then back to ARMED
module home_alarm_ctrl
  import home_alarm_pkg::*;
#(
  parameter int                 N_ZONES    = 4,
  parameter logic [N_ZONES-1:0] ENTRY_MASK = N_ZONES'(1),
  parameter int                 EXIT_DLY   = 16,
  parameter int                 ENTRY_DLY  = 16,
  parameter int                 SIREN_TIME = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] sw,
  input  logic               m,
  output logic               a,
  output logic               led1,
  output logic               led2,
  output logic               led3,
  output logic               led_pend,
  output logic [N_ZONES-1:0] zone_mem
);

  localparam int CW = cnt_width(EXIT_DLY, ENTRY_DLY, SIREN_TIME);
  localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
  localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_TIME - 1);

  alarm_state_t       r_state;
  alarm_state_t       w_next;
  logic [N_ZONES-1:0] r_zone_mem;
  logic               w_load;
  logic [CW-1:0]      w_load_val;
  logic               w_clr;
  logic               w_zero;
  logic               w_inst;
  logic               w_ent;

  assign w_inst = |(sw & ~ENTRY_MASK);
  assign w_ent  = |(sw & ENTRY_MASK);

  alarm_delay_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .clr      (w_clr),
    .zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DISARMED;
    end else begin
      r_state <= w_next;
    end
  end

  // Timer decrements on its own whenever neither load nor clr is asserted.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_clr      = 1'b0;
    if (!m) begin
      w_next = DISARMED;
      w_clr  = 1'b1;
    end else begin
      case (r_state)
        DISARMED: begin
          w_next     = EXIT;
          w_load     = 1'b1;
          w_load_val = EXIT_LD;
        end
        EXIT: begin
          if (w_zero) w_next = ARMED;
        end
        ARMED: begin
          if (w_inst) begin
            w_next     = ALARM;
            w_load     = 1'b1;
            w_load_val = SIREN_LD;
          end else if (w_ent) begin
            w_next     = ENTRY;
            w_load     = 1'b1;
            w_load_val = ENTRY_LD;
          end
        end
        ENTRY: begin
          if (w_inst || w_zero) begin
            w_next     = ALARM;
            w_load     = 1'b1;
            w_load_val = SIREN_LD;
          end
        end
        ALARM: begin
          if (w_zero) w_next = ARMED;
        end
        default: begin
          w_next = DISARMED;
          w_clr  = 1'b1;
        end
      endcase
    end
  end

  // Held while disarmed; cleared only on a fresh arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zone_mem <= '0;
    end else if (m) begin
      if (r_state == DISARMED) begin
        r_zone_mem <= '0;
      end else if (r_state == ARMED || r_state == ENTRY || r_state == ALARM) begin
        r_zone_mem <= r_zone_mem | sw;
      end
    end
  end

  assign a        = (r_state == ALARM);
  assign led1     = a;
  assign led2     = (r_state != DISARMED);
  assign led3     = ~led2;
  assign led_pend = (r_state == EXIT) || (r_state == ENTRY);
  assign zone_mem = r_zone_mem;

endmodule
